// File: rtl/tdm_defs_pkg.sv
// rtl/tdm_defs_pkg.sv - shared state encoding and default sizing for the TDM demultiplexer
package tdm_defs;
    localparam logic ST_HUNT = 1'b0;
    localparam logic ST_RECV = 1'b1;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;
endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - slot index counter with clear > load1 > en priority
module tdm_slot_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load1,
    input  logic          clear,
    output logic [CW-1:0] slot
);
    logic [CW-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = CW'(1);
        end else if (en) begin
            slot_d = slot_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - time-division demultiplexer: frames serial slot words into parallel channels
module tdm_demux
    import tdm_defs::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic [WIDTH-1:0]          din,
    input  logic                      frame_start,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic                      ch_valid,
    output logic                      sync_err,
    output logic                      busy
);
    localparam int            CW        = $clog2(CHANNELS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(CHANNELS - 1);

    logic                      state_q, state_d;
    logic [CW-1:0]             slot;
    logic                      cnt_en, cnt_load1, cnt_clear;
    logic                      commit, err;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS*WIDTH-1:0] ch_data_q, ch_data_d;
    logic                      ch_valid_q, sync_err_q;

    tdm_slot_counter #(.CW(CW)) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .load1 (cnt_load1),
        .clear (cnt_clear),
        .slot  (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: if (din_valid && frame_start) state_d = ST_RECV;
            ST_RECV: if (din_valid && !frame_start && slot == LAST_SLOT) state_d = ST_HUNT;
            default: state_d = ST_HUNT;
        endcase
    end

    // A frame_start word always restarts a frame; in RECV it also flags the abandoned partial frame.
    always_comb begin
        cnt_load1 = din_valid && frame_start;
        cnt_en    = din_valid && !frame_start && (state_q == ST_RECV);
        commit    = cnt_en && (slot == LAST_SLOT);
        cnt_clear = commit;
        err       = din_valid && frame_start && (state_q == ST_RECV);
    end

    always_comb begin
        shadow_d = shadow_q;
        if (cnt_load1) begin
            shadow_d[0 +: WIDTH] = din;
        end else if (cnt_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (slot == CW'(k)) shadow_d[k*WIDTH +: WIDTH] = din;
            end
        end
        // Committing from shadow_d lets the final slot go straight to the outputs.
        ch_data_d = commit ? shadow_d : ch_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            ch_data_q  <= '0;
            ch_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            ch_data_q  <= ch_data_d;
            ch_valid_q <= commit;
            sync_err_q <= err;
        end
    end

    assign ch_data  = ch_data_q;
    assign ch_valid = ch_valid_q;
    assign sync_err = sync_err_q;
    assign busy     = (state_q == ST_RECV);
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux against a queue-based frame model
module tb_tdm_demux;
    localparam int CH = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [W-1:0]  din = '0;
    logic          frame_start = 1'b0;
    logic [CH*W-1:0] ch_data;
    logic          ch_valid;
    logic          sync_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]    mq[$];
    logic [CH*W-1:0] exp_data;
    bit              exp_valid;
    bit              exp_err;

    tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .frame_start (frame_start),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .sync_err    (sync_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Frame model: a non-empty queue means a frame is being collected.
    task automatic model_step(bit v, bit fs, logic [W-1:0] d);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (v) begin
            if (fs) begin
                if (mq.size() != 0) exp_err = 1'b1;
                mq.delete();
                mq.push_back(d);
            end else if (mq.size() != 0) begin
                mq.push_back(d);
                if (mq.size() == CH) begin
                    for (int k = 0; k < CH; k++) exp_data[k*W +: W] = mq[k];
                    exp_valid = 1'b1;
                    mq.delete();
                end
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic drive(bit v, bit fs, logic [W-1:0] d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        model_step(v, fs, d);
        #1;
    endtask

    task automatic apply_reset();
        din_valid = 1'b0;
        frame_start = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n_valid;
        logic [W-1:0] a[4];
        a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        apply_reset();
        checks++;
        if ({ch_data, ch_valid, sync_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: data=%h valid=%b err=%b busy=%b required all 0", ch_data, ch_valid, sync_err, busy);
        end
        drive(1, 1, 8'h5A); drive(1, 0, 8'h6B); drive(1, 0, 8'h7C); drive(1, 0, 8'h8D);
        drive(1, 1, 8'h11); drive(1, 0, 8'h22);
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ch_data !== '0 || busy !== 1'b0 || ch_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: data=%h valid=%b err=%b busy=%b required all 0", ch_data, ch_valid, sync_err, busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, a[i]);
            if (ch_valid) n_valid++;
            checks++;
            if (ch_valid !== exp_valid || ch_data !== exp_data || busy !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL reset_frame[%0d]: valid=%b data=%h busy=%b required valid=%b data=%h busy=%b",
                         i, ch_valid, ch_data, busy, exp_valid, exp_data, mq.size() != 0);
            end
        end
        checks++;
        if (ch_data !== 32'hA4A3A2A1 || n_valid != 1) begin
            errors++;
            $display("FAIL reset_result: data=%h pulses=%0d required data=a4a3a2a1 pulses=1", ch_data, n_valid);
        end
    endtask

    task automatic test_stall();
        int n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, 8'(i + 1));
            if (ch_valid) n_valid++;
            checks++;
            if (ch_valid !== (i == 3)) begin
                errors++;
                $display("FAIL stall_word[%0d]: valid=%b required %b", i, ch_valid, i == 3);
            end
            if (i < 3) begin
                for (int s = 0; s < 3; s++) begin
                    drive(0, $urandom_range(0, 1), 8'($urandom));
                    if (ch_valid) n_valid++;
                    checks++;
                    if (ch_valid !== 1'b0 || busy !== 1'b1 || ch_data !== exp_data) begin
                        errors++;
                        $display("FAIL stall_idle[%0d.%0d]: valid=%b busy=%b data=%h required valid=0 busy=1 data=%h",
                                 i, s, ch_valid, busy, ch_data, exp_data);
                    end
                end
            end
        end
        drive(0, 0, 8'h00);
        if (ch_valid) n_valid++;
        checks++;
        if (ch_data !== 32'h04030201 || n_valid != 1) begin
            errors++;
            $display("FAIL stall_result: data=%h pulses=%0d required data=04030201 pulses=1", ch_data, n_valid);
        end
    endtask

    task automatic test_hunt_drop();
        int n_err = 0;
        logic [W-1:0] w[6];
        w = '{8'h55, 8'h66, 8'h10, 8'h20, 8'h30, 8'h40};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, i == 2, w[i]);
            if (sync_err) n_err++;
            checks++;
            if (busy !== (mq.size() != 0) || ch_valid !== exp_valid) begin
                errors++;
                $display("FAIL hunt_step[%0d]: busy=%b valid=%b required busy=%b valid=%b",
                         i, busy, ch_valid, mq.size() != 0, exp_valid);
            end
        end
        checks++;
        if (ch_data !== 32'h40302010 || n_err != 0) begin
            errors++;
            $display("FAIL hunt_result: data=%h sync_err pulses=%0d required data=40302010 pulses=0", ch_data, n_err);
        end
    endtask

    task automatic test_early_marker();
        int n_err = 0;
        logic [W-1:0] w[6];
        bit           f[6];
        w = '{8'h10, 8'h20, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        f = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive(1, f[i], w[i]);
            if (sync_err) n_err++;
            checks++;
            if (sync_err !== (i == 2)) begin
                errors++;
                $display("FAIL early_err[%0d]: sync_err=%b required %b", i, sync_err, i == 2);
            end
            if (i < 5) begin
                checks++;
                if (ch_data !== 32'h40302010 || ch_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_hold[%0d]: data=%h valid=%b required data=40302010 valid=0", i, ch_data, ch_valid);
                end
            end
        end
        checks++;
        if (ch_data !== 32'h0D0C0B0A || ch_valid !== 1'b1 || n_err != 1) begin
            errors++;
            $display("FAIL early_result: data=%h valid=%b errs=%0d required data=0d0c0b0a valid=1 errs=1", ch_data, ch_valid, n_err);
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        logic [CH*W-1:0] seen[$];
        logic [W-1:0] w[8];
        w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1, (i % 4) == 0, w[i]);
            else       drive(0, 0, 8'h00);
            if (ch_valid) begin
                pulses.push_back(i);
                seen.push_back(ch_data);
            end
            checks++;
            if (busy !== (mq.size() != 0) || sync_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_step[%0d]: busy=%b err=%b required busy=%b err=0", i, busy, sync_err, mq.size() != 0);
            end
        end
        checks++;
        if (pulses.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d required 2", pulses.size());
        end else begin
            checks++;
            if (pulses[1] - pulses[0] != 4 || seen[0] !== 32'h04030201 || seen[1] !== 32'hF4F3F2F1) begin
                errors++;
                $display("FAIL b2b_frames: gap=%0d data0=%h data1=%h required gap=4 data0=04030201 data1=f4f3f2f1",
                         pulses[1] - pulses[0], seen[0], seen[1]);
            end
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, $urandom_range(0, 1), 8'($urandom));
            if (ch_data !== 32'hF4F3F2F1 || ch_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d bad cycles, last data=%h valid=%b busy=%b required data=f4f3f2f1 valid=0 busy=0",
                     bad, ch_data, ch_valid, busy);
        end
    endtask

    task automatic test_random();
        bit v, fs;
        logic [W-1:0] d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            fs = ($urandom_range(0, 9) < 2);
            d  = 8'($urandom);
            drive(v, fs, d);
            checks++;
            if (ch_valid !== exp_valid || ch_data !== exp_data || sync_err !== exp_err || busy !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b data=%h err=%b busy=%b required valid=%b data=%h err=%b busy=%b",
                         i, ch_valid, ch_data, sync_err, busy, exp_valid, exp_data, exp_err, mq.size() != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_hunt_drop();
        test_early_marker();
        test_back_to_back();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
